// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: line filtering, 11-bit deframing with watchdog, E0/F0/E1 prefix
// decoding, held-key tracking and a show-ahead event FIFO with valid/ready handshake.
// Optional build macro PS2_ERR_COUNT_EN adds a saturating error counter output err_cnt.
module ps2_keyboard_rx #(
    parameter int unsigned         FILTER_LEN  = 8,
    parameter int unsigned         TIMEOUT_CYC = 100000,
    parameter int unsigned         FIFO_DEPTH  = 8,
    parameter int unsigned         N_KEYS      = 4,
    parameter logic [N_KEYS*9-1:0] KEY_CODES   = {9'h175, 9'h172, 9'h01D, 9'h01B}
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ps2_clk_in,
    input  logic              ps2_dat_in,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [7:0]        ev_code,
    output logic              ev_ext,
    output logic              ev_break,
    output logic [N_KEYS-1:0] key_held,
    output logic              frame_err,
    output logic              fifo_ovf
`ifdef PS2_ERR_COUNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
    localparam int unsigned WdW    = $clog2(TIMEOUT_CYC + 1);
    // frame_err is registered, so the timeout decision is taken one cycle early
    localparam int unsigned WdLast = TIMEOUT_CYC - 2;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    // ---------------- input conditioning ----------------
    logic [1:0]      clk_sync_q, dat_sync_q;
    logic [1:0]      raw_s;             // [0] clk, [1] data
    logic [1:0]      filt_q, filt_d;
    logic [1:0][7:0] fcnt_q, fcnt_d;
    logic            clk_dly_q;
    logic            strobe, bit_in;

    assign raw_s  = {dat_sync_q[1], clk_sync_q[1]};
    assign strobe = clk_dly_q & ~filt_q[0];
    assign bit_in = filt_q[1];

    // Two-flop synchronisers, filtered lines and previous filtered clock
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 2'b11;
            fcnt_q     <= '0;
            clk_dly_q  <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            clk_dly_q  <= filt_q[0];
        end
    end

    // Accept a line change only after FILTER_LEN consecutive differing samples
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            fcnt_d[i] = '0;
            if (raw_s[i] != filt_q[i]) begin
                if (fcnt_q[i] == 8'(FILTER_LEN - 1)) filt_d[i] = raw_s[i];
                else fcnt_d[i] = fcnt_q[i] + 8'd1;
            end
        end
    end

    // ---------------- deframer ----------------
    state_e         state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic           parity_q, parity_d;
    logic [WdW-1:0] wdog_q, wdog_d;
    logic           timeout, byte_ok, frame_bad;

    // Deframer state register and datapath
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            wdog_q    <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            parity_q  <= parity_d;
            wdog_q    <= wdog_d;
        end
    end

    // Next state: advance on each sample strobe, watchdog aborts a stalled frame
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        parity_d  = parity_q;
        wdog_d    = '0;
        timeout   = 1'b0;
        if (state_q != StIdle) begin
            wdog_d  = strobe ? '0 : wdog_q + WdW'(1);
            timeout = !strobe && (wdog_q == WdW'(WdLast));
        end
        if (timeout) begin
            state_d = StIdle;
            wdog_d  = '0;
        end else if (strobe) begin
            unique case (state_q)
                StIdle: begin
                    if (!bit_in) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end
                end
                StData: begin
                    shift_d   = {bit_in, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    parity_d = bit_in;
                    state_d  = StStop;
                end
                StStop:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Outputs: good byte or framing error at the stop bit, or watchdog abort
    always_comb begin
        byte_ok   = 1'b0;
        frame_bad = timeout;
        if (strobe && state_q == StStop) begin
            byte_ok   = (^{shift_q, parity_q}) & bit_in;
            frame_bad = ~byte_ok;
        end
    end

    logic       byte_vld_q, frame_err_q;
    logic [7:0] byte_q;

    // Register deframer results for the decoder
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byte_vld_q  <= 1'b0;
            byte_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            byte_vld_q  <= byte_ok;
            frame_err_q <= frame_bad;
            if (byte_ok) byte_q <= shift_q;
        end
    end

    // ---------------- prefix decoder and key tracking ----------------
    logic              ext_q, ext_d, brk_q, brk_d, push;
    logic [2:0]        skip_q, skip_d;
    logic [N_KEYS-1:0] held_q, held_d;

    // Prefix flags, pause-sequence skip counter and held keys
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= '0;
            held_q <= '0;
        end else begin
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            skip_q <= skip_d;
            held_q <= held_d;
        end
    end

    // Interpret each good byte; a framing error resets the prefix context
    always_comb begin
        ext_d  = ext_q;
        brk_d  = brk_q;
        skip_d = skip_q;
        push   = 1'b0;
        if (frame_err_q) begin
            ext_d  = 1'b0;
            brk_d  = 1'b0;
            skip_d = '0;
        end else if (byte_vld_q) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else begin
                case (byte_q)
                    8'hE0:   ext_d  = 1'b1;
                    8'hF0:   brk_d  = 1'b1;
                    8'hE1:   skip_d = 3'd7;
                    default: begin
                        push  = 1'b1;
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // Held state follows every emitted event, regardless of FIFO space
    always_comb begin
        held_d = held_q;
        if (push) begin
            for (int i = 0; i < int'(N_KEYS); i++) begin
                if ({ext_q, byte_q} == KEY_CODES[i*9 +: 9]) held_d[i] = ~brk_q;
            end
        end
    end

    // ---------------- event FIFO ----------------
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [PtrW:0] wr_ptr_q, rd_ptr_q;
    logic          full, pop, do_push, ovf_q;
    logic [9:0]    head;

    assign ev_valid = (wr_ptr_q != rd_ptr_q);
    assign full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {PtrW{1'b0}}});
    assign pop      = ev_valid & ev_ready;
    assign do_push  = push & (~full | pop);
    assign head     = mem_q[rd_ptr_q[PtrW-1:0]];

    // FIFO storage; {brk, ext, code}
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= {brk_q, ext_q, byte_q};
    end

    // FIFO pointers and overflow pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            ovf_q <= push & full & ~pop;
        end
    end

    assign ev_code   = ev_valid ? head[7:0] : 8'h00;
    assign ev_ext    = ev_valid & head[8];
    assign ev_break  = ev_valid & head[9];
    assign key_held  = held_q;
    assign frame_err = frame_err_q;
    assign fifo_ovf  = ovf_q;

`ifdef PS2_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of error cycles; simultaneous pulses count once
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) err_cnt_q <= '0;
        else if ((frame_err_q | ovf_q) && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: table-driven byte sequences plus hand-written
// latency, parity, timeout, overflow, glitch and mid-frame reset sequences.
module tb_ps2_keyboard_rx;

    localparam int unsigned FILT = 4;
    localparam int unsigned TMO  = 600;
    localparam int unsigned H    = 20;  // PS/2 half bit period in system clocks

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       ev_ready = 1'b0;
    logic       ev_valid, ev_ext, ev_break, frame_err, fifo_ovf;
    logic [7:0] ev_code;
    logic [3:0] key_held;
`ifdef PS2_ERR_COUNT_EN
    logic [7:0] err_cnt;
`endif

    ps2_keyboard_rx #(
        .FILTER_LEN (FILT),
        .TIMEOUT_CYC(TMO),
        .FIFO_DEPTH (8),
        .N_KEYS     (4),
        .KEY_CODES  ({9'h175, 9'h172, 9'h01D, 9'h01B})
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .ps2_clk_in(ps2_clk),
        .ps2_dat_in(ps2_dat),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_break  (ev_break),
        .key_held  (key_held),
        .frame_err (frame_err),
        .fifo_ovf  (fifo_ovf)
`ifdef PS2_ERR_COUNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail = 0;
    int         err_pulses = 0;
    int         ovf_pulses = 0;
    logic [9:0] popped[$];  // {brk, ext, code} of each accepted event

    // Monitor: count error pulses and record handshaked events
    always @(negedge clock) begin
        if (reset_n) begin
            if (frame_err) err_pulses++;
            if (fifo_ovf) ovf_pulses++;
            if (ev_valid && ev_ready) popped.push_back({ev_break, ev_ext, ev_code});
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "bench time limit");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = fr[i];
            tick(H);
            ps2_clk = 1'b0;
            tick(H);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(mkframe(b), 11);
        ps2_dat = 1'b1;
        tick(2 * H);
    endtask

    // Expect exactly one event since the queue was cleared
    task automatic check_event(input string name, input logic [7:0] code, input logic ext,
                               input logic brk, input logic [3:0] held);
        check({name, "_count"}, popped.size(), 1);
        if (popped.size() > 0) begin
            check({name, "_code"}, popped[0][7:0], code);
            check({name, "_ext"}, popped[0][8], ext);
            check({name, "_brk"}, popped[0][9], brk);
        end
        check({name, "_held"}, key_held, held);
    endtask

    typedef struct {
        int          nb;
        logic [71:0] seq;   // byte j at [j*8 +: 8]
        logic [7:0]  code;
        logic        ext;
        logic        brk;
        logic [3:0]  held;
    } vec_t;

    vec_t       vecs [11];
    logic [7:0] ovf_codes [9];
    logic [10:0] fr;
    int         e0, o0, first_at, pulses, base;

    initial begin
        // Held state starts at 4'b0010 from the first hand-written frame (0x1D)
        vecs[0]  = '{2, 72'h75E0, 8'h75, 1'b1, 1'b0, 4'b1010};
        vecs[1]  = '{3, 72'h75F0E0, 8'h75, 1'b1, 1'b1, 4'b0010};
        vecs[2]  = '{1, 72'h1B, 8'h1B, 1'b0, 1'b0, 4'b0011};
        vecs[3]  = '{2, 72'h1DF0, 8'h1D, 1'b0, 1'b1, 4'b0001};
        vecs[4]  = '{2, 72'h72E0, 8'h72, 1'b1, 1'b0, 4'b0101};
        vecs[5]  = '{1, 72'h72, 8'h72, 1'b0, 1'b0, 4'b0101};
        vecs[6]  = '{1, 72'h1B, 8'h1B, 1'b0, 1'b0, 4'b0101};
        vecs[7]  = '{3, 72'h72F0E0, 8'h72, 1'b1, 1'b1, 4'b0001};
        vecs[8]  = '{9, 72'h1D77F014F0E17714E1, 8'h1D, 1'b0, 1'b0, 4'b0011};
        vecs[9]  = '{2, 72'h1BF0, 8'h1B, 1'b0, 1'b1, 4'b0010};
        vecs[10] = '{2, 72'h1DF0, 8'h1D, 1'b0, 1'b1, 4'b0000};
        ovf_codes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h1B, 8'h1D};

        // Reset state
        tick(3);
        reset_n = 1'b1;
        tick(3);
        check("rst_valid", ev_valid, 0);
        check("rst_code", ev_code, 0);
        check("rst_ext", ev_ext, 0);
        check("rst_break", ev_break, 0);
        check("rst_held", key_held, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovf", fifo_ovf, 0);

        // 0x1D: ev_valid rises FILT+4 clocks after the stop falling edge is driven
        // (2 sync + FILT filter samples -> strobe, +1 byte register, +1 FIFO push)
        send_bits(mkframe(8'h1D), 10);
        ps2_dat = 1'b1;
        tick(H);
        ps2_clk = 1'b0;
        tick(FILT + 3);
        check("lat_early_valid", ev_valid, 0);
        check("lat_early_held", key_held, 4'b0000);
        tick(1);
        check("lat_valid", ev_valid, 1);
        check("lat_code", ev_code, 8'h1D);
        check("lat_ext", ev_ext, 0);
        check("lat_break", ev_break, 0);
        check("lat_held", key_held, 4'b0010);
        tick(H - FILT - 4);
        ps2_clk = 1'b1;
        tick(2 * H);
        ev_ready = 1'b1;
        tick(3);
        check("lat_pop_count", popped.size(), 1);
        check("lat_pop_empty", ev_valid, 0);

        // Table-driven prefix sequences
        for (int v = 0; v < 11; v++) begin
            popped.delete();
            for (int j = 0; j < vecs[v].nb; j++) send_byte(vecs[v].seq[j*8 +: 8]);
            check_event($sformatf("vec%0d", v), vecs[v].code, vecs[v].ext, vecs[v].brk,
                        vecs[v].held);
        end

        // Bad parity after E0: one error, no event, prefix context cleared
        e0 = err_pulses;
        popped.delete();
        send_byte(8'hE0);
        fr = mkframe(8'h72);
        fr[9] = ~fr[9];
        send_bits(fr, 11);
        ps2_dat = 1'b1;
        tick(2 * H);
        check("par_err_pulses", err_pulses - e0, 1);
        check("par_no_event", popped.size(), 0);
        send_byte(8'hF0);
        send_byte(8'h72);
        check_event("par_after", 8'h72, 1'b0, 1'b1, 4'b0000);

        // Timeout after 5 bits, preceded by E0 which must be forgotten
        e0 = err_pulses;
        popped.delete();
        send_byte(8'hE0);
        fr = mkframe(8'h55);
        send_bits(fr, 4);
        ps2_dat = fr[4];
        tick(H);
        ps2_clk = 1'b0;
        first_at = 0;
        pulses = 0;
        for (int n = 1; n <= int'(TMO + FILT + 12); n++) begin
            tick(1);
            if (n == int'(H)) ps2_clk = 1'b1;
            if (frame_err) begin
                pulses++;
                if (first_at == 0) first_at = n;
            end
        end
        // strobe is FILT+2 clocks after the drive, frame_err TMO clocks after the strobe
        check("tmo_cycle", first_at, FILT + 2 + TMO);
        check("tmo_pulses", pulses, 1);
        check("tmo_mon_pulses", err_pulses - e0, 1);
        check("tmo_no_event", popped.size(), 0);
        ps2_dat = 1'b1;
        tick(2 * H);
        send_byte(8'h1B);
        check_event("tmo_after", 8'h1B, 1'b0, 1'b0, 4'b0001);

        // FIFO overflow with consumer stalled
        ev_ready = 1'b0;
        popped.delete();
        o0 = ovf_pulses;
        for (int i = 0; i < 8; i++) send_byte(ovf_codes[i]);
        check("ovf_none_at_8", ovf_pulses - o0, 0);
        send_byte(ovf_codes[8]);
        check("ovf_pulse_9th", ovf_pulses - o0, 1);
        check("ovf_held", key_held, 4'b0011);
        check("ovf_head_valid", ev_valid, 1);
        check("ovf_head_code", ev_code, 8'h10);
        ev_ready = 1'b1;
        tick(12);
        check("ovf_pop_count", popped.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < popped.size())
                check($sformatf("ovf_pop%0d", i), popped[i][7:0], ovf_codes[i]);
        end
        check("ovf_drained", ev_valid, 0);

        // Clock glitches shorter than the filter during idle
        e0 = err_pulses;
        popped.delete();
        ps2_clk = 1'b0;
        tick(1);
        ps2_clk = 1'b1;
        tick(10);
        ps2_clk = 1'b0;
        tick(FILT - 1);
        ps2_clk = 1'b1;
        tick(10);
        ps2_clk = 1'b0;
        tick(1);
        ps2_clk = 1'b1;
        tick(30);
        check("glitch_no_err", err_pulses - e0, 0);
        check("glitch_no_event", popped.size(), 0);
        send_byte(8'hF0);
        send_byte(8'h1B);
        check_event("glitch_after", 8'h1B, 1'b0, 1'b1, 4'b0010);

        // Asynchronous reset in the middle of a frame
        ev_ready = 1'b0;
        popped.delete();
        send_byte(8'h1D);
        check("mid_pre_valid", ev_valid, 1);
        send_bits(mkframe(8'h1B), 4);
        reset_n = 1'b0;
        #1;
        check("mid_valid", ev_valid, 0);
        check("mid_code", ev_code, 0);
        check("mid_ext", ev_ext, 0);
        check("mid_break", ev_break, 0);
        check("mid_held", key_held, 0);
        check("mid_ferr", frame_err, 0);
        check("mid_ovf", fifo_ovf, 0);
        base = err_pulses + ovf_pulses;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        tick(3);
        reset_n = 1'b1;
        tick(3);
        ev_ready = 1'b1;
        send_byte(8'h1B);
        check_event("mid_after", 8'h1B, 1'b0, 1'b0, 4'b0001);

`ifdef PS2_ERR_COUNT_EN
        check("err_cnt", err_cnt, err_pulses + ovf_pulses - base);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- Parametrised PS/2 keyboard receiver, fully synchronous to the system clock.
- Filters the PS/2 lines, deframes 11-bit packets with start/parity/stop checks and a watchdog, and decodes E0/F0/E1 prefix sequences into make/break events.
- Events are buffered in a show-ahead FIFO with a valid/ready handshake.
- Maintains a held-state bitmask for a configurable key table; this drives paddle control (up/down for two players) in the game logic.

Parameters:
- FILTER_LEN, 8: consecutive identical samples needed to accept a PS/2 line change (1..255).
- TIMEOUT_CYC, 100000: clock cycles without a falling PS/2 clock edge before an in-progress frame is aborted (2 ms at 50 MHz).
- FIFO_DEPTH, 8: event FIFO entries; power of two, >= 2.
- N_KEYS, 4: tracked keys.
- KEY_CODES, {9'h175,9'h172,9'h01D,9'h01B}: N_KEYS x 9-bit entries {ext,code}; entry i drives key_held[i], with entry 0 in the LSBs. Default i=0 is S, 1 is W, 2 is down arrow, 3 is up arrow.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ps2_clk_in  in  1  raw PS/2 clock, asynchronous
- ps2_dat_in  in  1  raw PS/2 data, asynchronous
- ev_valid  out  1  FIFO head valid
- ev_ready  in  1  consumer accepts head
- ev_code  out  8  scan code at head (0 when empty)
- ev_ext  out  1  head event had E0 prefix
- ev_break  out  1  head event is a release (F0 prefix)
- key_held  out  N_KEYS  held state per KEY_CODES entry
- frame_err  out  1  one-cycle pulse: bad start/parity/stop, or timeout
- fifo_ovf  out  1  one-cycle pulse: event dropped because FIFO full

Behaviour:
- Reset values:
  - All outputs 0; FIFO empty.
  - Deframer in IDLE; prefix flags clear; filtered lines = 1.
  - Reset mid-frame discards the partial frame and clears key_held.
- Input conditioning:
  - Two-flop synchroniser on each line, then a per-line filter: the filtered value changes only after FILTER_LEN consecutive equal synchronised samples.
  - A falling edge = filtered clk 1->0 seen on one clock; it produces a one-cycle sample strobe.
  - The data bit is the filtered data value at the strobe.
- Deframer states: IDLE, DATA, PARITY, STOP.
  - IDLE: on strobe with data=0 go to DATA, bit count=0. On strobe with data=1 stay in IDLE, no error.
  - DATA: shift LSB-first; after the 8th bit go to PARITY.
  - PARITY: capture the bit, go to STOP.
  - STOP: frame is good if odd parity over data+parity holds and stop=1; otherwise pulse frame_err. Either way return to IDLE.
  - Watchdog counter clears on every strobe. In any state other than IDLE, reaching TIMEOUT_CYC forces IDLE and pulses frame_err. In IDLE the counter is held at 0.
- Decoder, acting on each good byte:
  - E0: set ext flag.
  - F0: set brk flag.
  - E1: discard the next 7 good bytes (Pause sequence); no event.
  - Any other byte: emit event {code, ext, brk}, then clear both flags.
  - A frame error or timeout clears ext/brk and any pending E1 skip.
- Latency: ev_valid rises 2 clocks after the stop-bit strobe when the FIFO was empty. key_held updates on the same cycle the event is pushed.
- Key tracking:
  - An event whose {ext,code} matches entry i sets key_held[i] on make and clears it on break.
  - Typematic repeats emit an event each time; key_held stays 1.
  - Key tracking is independent of FIFO occupancy.
- FIFO:
  - Show-ahead; a pop occurs when ev_valid & ev_ready.
  - A push when full is accepted only if a pop happens in the same cycle. Otherwise the event is dropped, fifo_ovf pulses, and the contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Empty: ev_valid=0 and ev_code/ev_ext/ev_break=0. ev_ready while empty is ignored.

Optional Feature:
- Macro: PS2_ERR_COUNT_EN.
- Defined:
  - Adds output err_cnt [7:0].
  - Increments on each frame_err and fifo_ovf pulse; +1 only if both pulse in the same cycle.
  - Saturates at 255; reset to 0.
- Undefined: no port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset, then frame 0x1D (start 0, bits LSB-first, parity 1, stop 1) at 12.5 kHz -> ev_valid=1, ev_code=0x1D, ev_ext=0, ev_break=0; key_held=4'b0010 two clocks after the stop strobe.
- Bytes E0 75, then E0 F0 75 -> events {0x75,ext=1,brk=0} then {0x75,ext=1,brk=1}; key_held[3] goes 1 then 0; no events emitted for prefix bytes.
- Frame 0x72 with parity bit 0 -> frame_err pulses once, no event. Following good F0 72 -> a single break event with ext=0, showing the prefix state was cleared correctly.
- Stop PS/2 clock after 5 bits for TIMEOUT_CYC+10 cycles -> frame_err at exactly TIMEOUT_CYC after the last strobe; the next full frame 0x1B decodes correctly.
- ev_ready=0, send FIFO_DEPTH+1 make codes -> FIFO holds the first 8 in order, fifo_ovf pulses on the 9th, key_held still updated. Then raise ev_ready -> 8 pops, ev_valid drops.
- Glitch: 1-cycle low pulses on ps2_clk_in, shorter than FILTER_LEN, during IDLE -> no strobe, no error, no event. Also assert reset_n low mid-frame -> all outputs 0 immediately.
